// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial deserializer: FSM state encoding
// and the even-parity helper used when SERIAL_DESER_PARITY_EN is defined.
package serial_deser_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

  // Returns the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [63:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/sipo_reg.sv
// WIDTH-bit serial-in/parallel-out shift register; new bits enter at the MSB
// so that an LSB-first stream lands in natural bit order after WIDTH strobes.
module sipo_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             shift_in,
  input  logic             clear,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign data_next[gi] = data_reg[gi+1];
    end
  endgenerate
  assign data_next[WIDTH-1] = shift_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (clear) begin
      data_reg <= '0;
    end else if (shift_en) begin
      data_reg <= data_next;
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver with a 1-entry valid/ready output buffer.
// Define SERIAL_DESER_PARITY_EN to append an even-parity bit to every word.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Shift_En,
  input  logic             Shift_In,
  input  logic             Clear,
  input  logic             Out_Ready,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Data_Out,
  output logic [CW-1:0]    Bit_Count,
  output logic             Overrun,
  output logic             Parity_Err
);

  state_t           state_reg, state_next;
  logic [CW-1:0]    bit_count_reg, bit_count_next;
  logic [WIDTH-1:0] sr_data;
  logic [WIDTH-1:0] shifted_word;
  logic [WIDTH-1:0] word_val;
  logic             sr_shift;
  logic             word_done;
  logic             out_valid_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             overrun_reg;
`ifdef SERIAL_DESER_PARITY_EN
  logic             parity_bad;
  logic             parity_err_reg;
`endif

  sipo_reg #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .shift_en(sr_shift),
    .shift_in(Shift_In),
    .clear   (Clear),
    .data    (sr_data)
  );

  // Value the register will hold after this strobe; the completed word is
  // taken from here so it reaches the buffer on the same edge.
  assign shifted_word = {Shift_In, sr_data[WIDTH-1:1]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= S_DATA;
      bit_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      bit_count_reg <= bit_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_count_next = bit_count_reg;
    sr_shift       = 1'b0;
    word_done      = 1'b0;
    word_val       = shifted_word;
`ifdef SERIAL_DESER_PARITY_EN
    parity_bad     = 1'b0;
`endif
    if (Clear) begin
      state_next     = S_DATA;
      bit_count_next = '0;
    end else if (Shift_En) begin
      case (state_reg)
        S_DATA: begin
          sr_shift = 1'b1;
          if (bit_count_reg == CW'(WIDTH - 1)) begin
`ifdef SERIAL_DESER_PARITY_EN
            state_next     = S_PAR;
            bit_count_next = bit_count_reg + 1'b1;
`else
            word_done      = 1'b1;
            bit_count_next = '0;
`endif
          end else begin
            bit_count_next = bit_count_reg + 1'b1;
          end
        end
        S_PAR: begin
          // Parity bit is not shifted in; the data word is already complete.
`ifdef SERIAL_DESER_PARITY_EN
          word_done  = 1'b1;
          word_val   = sr_data;
          parity_bad = even_parity(64'(sr_data)) ^ Shift_In;
`endif
          state_next     = S_DATA;
          bit_count_next = '0;
        end
        default: begin
          state_next     = S_DATA;
          bit_count_next = '0;
        end
      endcase
    end
  end

  // Output buffer: a completing word loads only if the slot is free or is
  // being drained this same edge; otherwise it is dropped and flagged.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_reg  <= 1'b0;
      data_out_reg   <= '0;
      overrun_reg    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      if (word_done) begin
        if (!out_valid_reg || Out_Ready) begin
          out_valid_reg  <= 1'b1;
          data_out_reg   <= word_val;
`ifdef SERIAL_DESER_PARITY_EN
          parity_err_reg <= parity_bad;
`endif
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (out_valid_reg && Out_Ready) begin
        out_valid_reg <= 1'b0;
      end
      if (Clear) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign Out_Valid = out_valid_reg;
  assign Data_Out  = data_out_reg;
  assign Bit_Count = bit_count_reg;
  assign Overrun   = overrun_reg;
`ifdef SERIAL_DESER_PARITY_EN
  assign Parity_Err = parity_err_reg;
`else
  assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer: stimulus pushes expected words,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_serial_deserializer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b1;
  logic             Shift_En = 1'b0;
  logic             Shift_In = 1'b0;
  logic             Clear = 1'b0;
  logic             Out_Ready = 1'b0;
  logic             Out_Valid;
  logic [WIDTH-1:0] Data_Out;
  logic [CW-1:0]    Bit_Count;
  logic             Overrun;
  logic             Parity_Err;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit               bits_q[$];

  serial_deserializer #(
    .WIDTH(WIDTH)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Shift_En  (Shift_En),
    .Shift_In  (Shift_In),
    .Clear     (Clear),
    .Out_Ready (Out_Ready),
    .Out_Valid (Out_Valid),
    .Data_Out  (Data_Out),
    .Bit_Count (Bit_Count),
    .Overrun   (Overrun),
    .Parity_Err(Parity_Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Appends a word LSB first, plus its even-parity bit when parity is built in.
  task automatic queue_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) bits_q.push_back(w[i]);
`ifdef SERIAL_DESER_PARITY_EN
    bits_q.push_back(^w);
`endif
  endtask

  // Called at posedge+1; drives one bit per cycle with no gaps.
  task automatic send_bits();
    while (bits_q.size() > 0) begin
      Shift_En = 1'b1;
      Shift_In = bits_q.pop_front();
      @(posedge Clk);
      #1;
    end
    Shift_En = 1'b0;
    Shift_In = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n && Out_Valid && Out_Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got %0h required no word", Data_Out);
      end else begin
        check("xfer_data", 32'(Data_Out), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 Reset_n = 1'b0;
    idle(2);
    check("rst_valid", 32'(Out_Valid), 0);
    check("rst_data", 32'(Data_Out), 0);
    check("rst_count", 32'(Bit_Count), 0);
    check("rst_overrun", 32'(Overrun), 0);
    check("rst_parity", 32'(Parity_Err), 0);
    Reset_n = 1'b1;
    idle(1);

    // 1: single word, consumer stalled
    exp_q.push_back(8'hA5);
    queue_word(8'hA5);
    send_bits();
    check("t1_valid", 32'(Out_Valid), 1);
    check("t1_data", 32'(Data_Out), 32'h A5);
    check("t1_count", 32'(Bit_Count), 0);

    // 2: overrun while full, then drain and clear the flag
    queue_word(8'h3C);
    send_bits();
    check("t2_data_held", 32'(Data_Out), 32'hA5);
    check("t2_overrun", 32'(Overrun), 1);
    check("t2_valid", 32'(Out_Valid), 1);
    Out_Ready = 1'b1;
    idle(1);
    Out_Ready = 1'b0;
    check("t2_valid_drop", 32'(Out_Valid), 0);
    Clear = 1'b1;
    idle(1);
    Clear = 1'b0;
    check("t2_overrun_clr", 32'(Overrun), 0);

    // 3: back-to-back words with continuous strobe
    Out_Ready = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    queue_word(8'h01);
    queue_word(8'hFF);
    send_bits();
    idle(3);
    check("t3_overrun", 32'(Overrun), 0);
    check("t3_drained", 32'(exp_q.size()), 0);

    // 4: partial word aborted by Clear that collides with a strobe
    bits_q.push_back(1'b1);
    bits_q.push_back(1'b0);
    bits_q.push_back(1'b1);
    send_bits();
    check("t4_partial", 32'(Bit_Count), 3);
    Shift_En = 1'b1;
    Shift_In = 1'b1;
    Clear    = 1'b1;
    idle(1);
    Clear    = 1'b0;
    Shift_En = 1'b0;
    check("t4_count_clr", 32'(Bit_Count), 0);
    exp_q.push_back(8'h5A);
    queue_word(8'h5A);
    send_bits();
    check("t4_valid", 32'(Out_Valid), 1);
    check("t4_data", 32'(Data_Out), 32'h5A);
    idle(2);
    check("t4_drained", 32'(exp_q.size()), 0);

    // 5: asynchronous reset mid-word with a full buffer
    Out_Ready = 1'b0;
    queue_word(8'h77);
    send_bits();
    check("t5_valid", 32'(Out_Valid), 1);
    for (int i = 0; i < 5; i++) bits_q.push_back(1'b1);
    send_bits();
    check("t5_count", 32'(Bit_Count), 5);
    #2 Reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(Out_Valid), 0);
    check("t5_rst_data", 32'(Data_Out), 0);
    check("t5_rst_count", 32'(Bit_Count), 0);
    check("t5_rst_overrun", 32'(Overrun), 0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    idle(1);

`ifdef SERIAL_DESER_PARITY_EN
    // 6: parity good then parity bad
    Out_Ready = 1'b1;
    for (int i = 0; i < WIDTH; i++) bits_q.push_back(i < 3);
    bits_q.push_back(1'b1);
    exp_q.push_back(8'h07);
    send_bits();
    check("t6_parity_ok", 32'(Parity_Err), 0);
    for (int i = 0; i < WIDTH; i++) bits_q.push_back(i < 3);
    bits_q.push_back(1'b0);
    exp_q.push_back(8'h07);
    send_bits();
    check("t6_parity_bad", 32'(Parity_Err), 1);
`endif

    idle(3);
    check("final_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
